// File: rtl/jpeg_bs_pkg.sv
// Shared types and helpers for the JPEG bitstream unpacker.
// Entry format, fill convention and FSM state encodings live here.
package jpeg_bs_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       is_last;
        logic [4:0] count;
        word_t      data;
    } bs_entry_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] FILL_BYTE      = 8'hFF;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Bytes to emit for an entry: full words give 4, partial words ceil(count/8).
    function automatic logic [2:0] entry_nbytes(input bs_entry_t e);
        return e.is_last ? 3'((6'(e.count) + 6'd7) >> 3) : 3'(BYTES_PER_WORD);
    endfunction

    // Every bit below count becomes 1; only the final emitted byte is affected.
    function automatic word_t pad_entry(input bs_entry_t e);
        return e.is_last ? (e.data | ({BYTES_PER_WORD{FILL_BYTE}} >> e.count)) : e.data;
    endfunction

endpackage

// File: rtl/jpeg_bs_word_fifo.sv
// First-word-fall-through FIFO of bitstream entries.
// Pointers carry one extra MSB so full and empty are distinguishable.
module jpeg_bs_word_fifo
    import jpeg_bs_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  bs_entry_t          wr_entry,
    input  logic               pop,
    output bs_entry_t          rd_entry,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    bs_entry_t   mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        wr_en;
    logic        rd_en;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en    = pop && !empty;
    // A pop frees the slot being written, so push-while-full is allowed then.
    assign wr_en    = push && (!full || rd_en);
    assign rd_entry = mem[rptr[AW-1:0]];
    assign level    = LEVEL_W'(wptr - rptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + (AW+1)'(1);
            if (rd_en) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/jpeg_bitstream_unpacker.sv
// Turns encoder words (plus the final partial word) into an MSB-first byte stream.
// Define JPEG_UNSTUFF_EN to drop a 0x00 that follows an emitted 0xFF.
module jpeg_bitstream_unpacker
    import jpeg_bs_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        JPEG_bitstream,
    input  logic               data_ready,
    input  logic               eof_data_partial_ready,
    input  logic [4:0]         end_of_file_bitstream_count,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               byte_last,
    output logic               stream_done,
    output logic               overflow,
    output logic               protocol_err,
    output logic [LEVEL_W-1:0] fifo_level
);
    logic [1:0] state;
    word_t      sreg;
    logic [2:0] nbytes;
    logic       cur_last;

    logic       wr_any;
    logic       push;
    bs_entry_t  wr_entry;
    bs_entry_t  head;
    logic [2:0] head_nb;
    logic       full;
    logic       empty;
    logic [7:0] cur_byte;
    logic       drop;
    logic       ff_tail;
    logic       accept;
    logic       adv;
    logic       fin;
    logic       load_now;

    assign wr_any = data_ready || eof_data_partial_ready;
    assign push   = wr_any && (state != DONE);

    // Simultaneous strobes are stored as the partial word.
    always_comb begin
        wr_entry.is_last = eof_data_partial_ready;
        wr_entry.count   = eof_data_partial_ready ? end_of_file_bitstream_count : 5'd0;
        wr_entry.data    = JPEG_bitstream;
    end

    jpeg_bs_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEVEL_W    (LEVEL_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (load_now),
        .rd_entry (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    assign head_nb  = entry_nbytes(head);
    assign cur_byte = sreg[31:24];

`ifdef JPEG_UNSTUFF_EN
    logic prev_ff;

    assign drop    = (state == SHIFT) && prev_ff && (cur_byte == 8'h00);
    // A trailing 0x00 right behind this 0xFF will vanish, so the 0xFF is the real last byte.
    assign ff_tail = (nbytes == 3'd2) && (cur_byte == FILL_BYTE) && (sreg[23:16] == 8'h00);

    always_ff @(posedge clk) begin
        if (rst)         prev_ff <= 1'b0;
        else if (accept) prev_ff <= (cur_byte == FILL_BYTE);
        else if (drop)   prev_ff <= 1'b0;
    end
`else
    assign drop    = 1'b0;
    assign ff_tail = 1'b0;
`endif

    assign byte_valid  = (state == SHIFT) && !drop;
    assign byte_out    = byte_valid ? cur_byte : 8'h00;
    assign byte_last   = byte_valid && cur_last && ((nbytes == 3'd1) || ff_tail);
    assign accept      = byte_valid && byte_ready;
    assign adv         = accept || drop;
    assign fin         = (accept && byte_last) || (adv && (nbytes == 3'd1));
    // Popping on the final accept keeps the output at one byte per cycle.
    assign load_now    = ((state == LOAD) || (fin && !cur_last)) && !empty;
    assign stream_done = (fin && cur_last) || (load_now && (head_nb == 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sreg         <= '0;
            nbytes       <= '0;
            cur_last     <= 1'b0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if ((wr_any && state == DONE) || (data_ready && eof_data_partial_ready))
                protocol_err <= 1'b1;
            if (push && full && !load_now)
                overflow <= 1'b1;

            case (state)
                IDLE: if (!empty || push) state <= LOAD;
                LOAD: if (empty) state <= IDLE;
                SHIFT: begin
                    if (fin) begin
                        if (cur_last)   state <= DONE;
                        else if (empty) state <= IDLE;
                    end else if (adv) begin
                        sreg   <= {sreg[23:0], 8'h00};
                        nbytes <= nbytes - 3'd1;
                    end
                end
                default: ;
            endcase

            if (load_now) begin
                sreg     <= pad_entry(head);
                nbytes   <= head_nb;
                cur_last <= head.is_last;
                state    <= (head_nb == 3'd0) ? DONE : SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// Scoreboard bench for jpeg_bitstream_unpacker: stimulus queues expected bytes,
// a negedge monitor pops and compares them as the DUT hands bytes over.
module tb_jpeg_bitstream_unpacker;
    localparam int FIFO_DEPTH = 8;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        JPEG_bitstream = '0;
    logic               data_ready = 1'b0;
    logic               eof_data_partial_ready = 1'b0;
    logic [4:0]         end_of_file_bitstream_count = '0;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               byte_ready = 1'b0;
    logic               byte_last;
    logic               stream_done;
    logic               overflow;
    logic               protocol_err;
    logic [LEVEL_W-1:0] fifo_level;

    jpeg_bitstream_unpacker #(.FIFO_DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .JPEG_bitstream              (JPEG_bitstream),
        .data_ready                  (data_ready),
        .eof_data_partial_ready      (eof_data_partial_ready),
        .end_of_file_bitstream_count (end_of_file_bitstream_count),
        .byte_out                    (byte_out),
        .byte_valid                  (byte_valid),
        .byte_ready                  (byte_ready),
        .byte_last                   (byte_last),
        .stream_done                 (stream_done),
        .overflow                    (overflow),
        .protocol_err                (protocol_err),
        .fifo_level                  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   exp_done  = 0;
    bit   m_prev_ff = 1'b0;
    int   n_checks  = 0;
    int   n_err     = 0;
    int   n_acc     = 0;
    int   rmode     = 3;
    int   phase     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference byte stream: each byte goes through the optional unstuffing rule.
    task automatic sb_add(input logic [7:0] b, input logic last);
        exp_t e;
`ifdef JPEG_UNSTUFF_EN
        if (m_prev_ff && b == 8'h00) begin
            m_prev_ff = 1'b0;
            if (last && sbq.size() != 0) sbq[sbq.size()-1].last = 1'b1;
            return;
        end
        m_prev_ff = (b == 8'hFF);
`endif
        e.b    = b;
        e.last = last;
        sbq.push_back(e);
    endtask

    task automatic model_word(input logic [31:0] w, input logic eof, input logic [4:0] cnt);
        int         nb;
        logic [7:0] b;
        nb = eof ? (int'(cnt) + 7) / 8 : 4;
        for (int k = 0; k < nb; k++) begin
            b = w[31-8*k -: 8];
            if (eof)
                for (int i = 0; i < 8; i++)
                    if (8*k + i >= int'(cnt)) b[7-i] = 1'b1;
            sb_add(b, eof && (k == nb - 1));
        end
        if (eof) exp_done++;
    endtask

    task automatic push_word(input logic [31:0] w, input logic dr, input logic eof,
                             input logic [4:0] cnt, input bit keep);
        JPEG_bitstream              = w;
        data_ready                  = dr;
        eof_data_partial_ready      = eof;
        end_of_file_bitstream_count = cnt;
        if (keep) model_word(w, eof, cnt);
        tick();
        data_ready             = 1'b0;
        eof_data_partial_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        exp_done  = 0;
        m_prev_ff = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || exp_done != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_pending", sbq.size() + exp_done, 0);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w = $urandom();
`ifdef JPEG_UNSTUFF_EN
        w &= 32'h7F7F7F7F;
`endif
        return w;
    endfunction

    // byte_ready generator, applied just after the main thread's drive point
    always begin
        @(posedge clk);
        #2;
        case (rmode)
            0: byte_ready = 1'b1;
            1: begin
                byte_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end
            2: byte_ready = ($urandom_range(3) != 0);
            default: byte_ready = 1'b0;
        endcase
    end

    bit         prev_stall = 1'b0;
    logic [7:0] prev_b     = '0;
    logic       prev_last  = 1'b0;
    bit         rst_q      = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_stall && !rst_q) begin
                chk("stall_valid", byte_valid, 1);
                chk("stall_byte", byte_out, prev_b);
                chk("stall_last", byte_last, prev_last);
            end
            if (byte_valid && byte_ready) begin
                n_acc++;
                if (sbq.size() == 0) begin
                    chk("unexpected_byte", byte_out, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("byte_out", byte_out, e.b);
                    chk("byte_last", byte_last, e.last);
                end
            end
            if (stream_done) begin
                chk("stream_done_ok", (exp_done > 0 && sbq.size() == 0), 1);
                if (exp_done > 0) exp_done--;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_b     = byte_out;
            prev_last  = byte_last;
        end else begin
            prev_stall = 1'b0;
        end
        rst_q = rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bit perr_exp;
        tick();
        tick();
        do_reset();
        chk("rst_valid", byte_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {overflow, protocol_err, stream_done, byte_last}, 0);
        chk("rst_byte", byte_out, 0);

        // full word then empty eof; first byte two cycles after the strobe
        rmode = 0;
        push_word(32'h12345678, 1, 0, 0, 1);
        chk("lat_n1_valid", byte_valid, 0);
        tick();
        chk("lat_n2_valid", byte_valid, 1);
        chk("lat_n2_byte", byte_out, 8'h12);
        push_word(32'h0, 0, 1, 5'd0, 1);
        wait_drain();

        // partial word with fill bits, then a strobe after the stream is done
        do_reset();
        push_word(32'hABC00000, 0, 1, 5'd13, 1);
        wait_drain();
        push_word(32'h55555555, 1, 0, 0, 0);
        chk("done_strobe_err", protocol_err, 1);
        chk("done_strobe_level", fifo_level, 0);

        // backpressure
        do_reset();
        rmode = 1;
        push_word(32'h01020304, 1, 0, 0, 1);
        push_word(32'hA0B0C0D0, 1, 0, 0, 1);
        push_word(32'h11223344, 1, 0, 0, 1);
        push_word(32'h0, 0, 1, 5'd0, 1);
        wait_drain();
        chk("bp_flags", {overflow, protocol_err}, 0);

        // overflow: one word sits in the shift register while the FIFO fills
        do_reset();
        rmode = 3;
        for (int i = 0; i < FIFO_DEPTH + 2; i++)
            push_word(rnd_word(), 1, 0, 0, i <= FIFO_DEPTH);
        chk("ovf_level", fifo_level, FIFO_DEPTH);
        chk("ovf_flag", overflow, 1);
        rmode = 0;
        repeat (6) tick();
        push_word(32'h0, 0, 1, 5'd0, 1);
        wait_drain();
        chk("ovf_sticky", overflow, 1);

        // reset in the middle of a word
        do_reset();
        base = n_acc;
        push_word(32'hCAFEBABE, 1, 0, 0, 1);
        n = 0;
        while (n_acc < base + 2 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_rst_accepted", n_acc - base, 2);
        rmode = 3;
        do_reset();
        chk("mid_rst_valid", byte_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_flags", {overflow, protocol_err, byte_last}, 0);
        rmode = 0;
        push_word(32'h89ABCDEF, 1, 0, 0, 1);
        push_word(32'h7E000000, 0, 1, 5'd31, 1);
        wait_drain();

        // both strobes together: stored as partial, flagged
        do_reset();
        push_word(32'h3C5A0000, 1, 1, 5'd8, 1);
        chk("both_strobe_err", protocol_err, 1);
        wait_drain();

        // FF/00 sequence
        do_reset();
        push_word(32'h41FF0042, 1, 0, 0, 1);
        push_word(32'hFF000000, 0, 1, 5'd16, 1);
        wait_drain();

        // randomized streams
        for (int s = 0; s < 8; s++) begin
            do_reset();
            rmode = 2;
            perr_exp = 1'b0;
            for (int w = 0; w < 1 + int'($urandom_range(6)); w++) begin
                repeat ($urandom_range(3)) tick();
                n = 0;
                while (fifo_level >= LEVEL_W'(FIFO_DEPTH - 2) && n < 200) begin
                    tick();
                    n++;
                end
                push_word(rnd_word(), 1, 0, 0, 1);
            end
            if ($urandom_range(4) == 0) begin
                perr_exp = 1'b1;
                push_word(rnd_word(), 1, 1, 5'($urandom_range(31)), 1);
            end else begin
                push_word(rnd_word(), 0, 1, 5'($urandom_range(31)), 1);
            end
            wait_drain();
            chk("rand_overflow", overflow, 0);
            chk("rand_protocol_err", protocol_err, perr_exp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
